// File: rtl/biu_pkg.sv
// biu_pkg: shared types, default sizing and physical-address helper for the prefetch unit.
package biu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int DEF_DEPTH     = 6;
   localparam int DEF_OUT_BYTES = 4;

   // Real-mode translation: segment * 16 + offset, wrapping at 1 MiB.
   function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
      return {seg, 4'h0} + {4'h0, off};
   endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: circular byte queue with single-byte push, multi-byte pop, clear and a head window.
module prefetch_fifo #(
   parameter int DEPTH     = 6,
   parameter int OUT_BYTES = 4,
   parameter int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   push,
   input  logic [7:0]             din,
   input  logic                   pop,
   input  logic [2:0]             pop_len,
   output logic [CNT_W-1:0]       count,
   output logic [8*OUT_BYTES-1:0] window
);

   localparam int           PW  = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [PW:0]  DEP = (PW + 1)'(DEPTH);

   logic [7:0]       mem_q [DEPTH];
   logic [7:0]       mem_d [DEPTH];
   logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pop_ok;

   // Pointer sums never exceed 2*DEPTH-2, so a single subtraction wraps them.
   function automatic logic [PW-1:0] wrap(input logic [PW:0] v);
      return v >= DEP ? PW'(v - DEP) : PW'(v);
   endfunction

   always_comb begin
      pop_ok = pop && pop_len != 3'd0 && int'(pop_len) <= int'(cnt_q) && int'(pop_len) <= OUT_BYTES;
      mem_d  = mem_q;
      if (push) mem_d[wr_q] = din;
      wr_d   = push ? wrap({1'b0, wr_q} + (PW + 1)'(1)) : wr_q;
      rd_d   = pop_ok ? wrap({1'b0, rd_q} + (PW + 1)'(pop_len)) : rd_q;
      cnt_d  = cnt_q + CNT_W'(push) - (pop_ok ? CNT_W'(pop_len) : '0);
      if (clear) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) mem_q <= mem_d;

   assign count = cnt_q;

   for (genvar i = 0; i < OUT_BYTES; i++) begin : g_lane
      logic [PW-1:0] idx;
      assign idx             = wrap({1'b0, rd_q} + (PW + 1)'(i));
      assign window[8*i +: 8] = int'(cnt_q) > i ? mem_q[idx] : 8'h00;
   end

endmodule

// File: rtl/biu_prefetch_unit.sv
// biu_prefetch_unit: fetches code bytes from CS:IP into a prefetch queue, flushes on IP load.
// Define BIU_PREFETCH_STATS_EN to add saturating fetch_cnt/flush_cnt outputs.
module biu_prefetch_unit
   import biu_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int OUT_BYTES = DEF_OUT_BYTES,
   parameter int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [15:0]            cs_base,
   input  logic                   ip_load,
   input  logic [15:0]            ip_load_val,
   output logic                   bus_req,
   output logic [19:0]            bus_addr,
   input  logic                   bus_ack,
   input  logic [7:0]             bus_data,
   output logic [8*OUT_BYTES-1:0] instr,
   output logic [CNT_W-1:0]       instr_count,
   input  logic                   consume,
   input  logic [2:0]             consume_len,
   output logic [15:0]            fetch_ip
`ifdef BIU_PREFETCH_STATS_EN
  ,output logic [15:0]            fetch_cnt,
   output logic [15:0]            flush_cnt
`endif
);

   state_t      state_q, state_d;
   logic [15:0] fetch_ip_q, fetch_ip_d;
   logic [19:0] bus_addr_q, bus_addr_d;
   logic        bus_req_q, bus_req_d;
   logic        push;

   always_comb begin
      state_d    = state_q;
      fetch_ip_d = fetch_ip_q;
      bus_addr_d = bus_addr_q;
      push       = 1'b0;
      case (state_q)
         IDLE: if (!ip_load && int'(instr_count) < DEPTH) begin
            state_d    = FETCH;
            bus_addr_d = phys_addr(cs_base, fetch_ip_q);
         end
         FETCH: if (bus_ack) begin
            state_d    = IDLE;
            push       = !ip_load;
            fetch_ip_d = fetch_ip_q + 16'd1;
         end else if (ip_load) begin
            state_d = DRAIN;
         end
         DRAIN: if (bus_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (ip_load) fetch_ip_d = ip_load_val;
      bus_req_d = state_d != IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         fetch_ip_q <= '0;
         bus_addr_q <= '0;
         bus_req_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_ip_q <= fetch_ip_d;
         bus_addr_q <= bus_addr_d;
         bus_req_q  <= bus_req_d;
      end
   end

   prefetch_fifo #(
      .DEPTH     (DEPTH),
      .OUT_BYTES (OUT_BYTES),
      .CNT_W     (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear   (ip_load),
      .push    (push),
      .din     (bus_data),
      .pop     (consume && !ip_load),
      .pop_len (consume_len),
      .count   (instr_count),
      .window  (instr)
   );

   assign bus_req  = bus_req_q;
   assign bus_addr = bus_addr_q;
   assign fetch_ip = fetch_ip_q;

`ifdef BIU_PREFETCH_STATS_EN
   logic [15:0] fetch_cnt_q, fetch_cnt_d, flush_cnt_q, flush_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q + 16'(push && fetch_cnt_q != 16'hFFFF);
      flush_cnt_d = flush_cnt_q + 16'(ip_load && flush_cnt_q != 16'hFFFF);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule
